// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the fetch aligner slice.
package rv_fetch_pkg;

  localparam int unsigned PARCEL_BITS = 16;

  // One queued 16-bit parcel plus the access-fault tag of the beat it came from.
  typedef struct packed {
    logic                   fault;
    logic [PARCEL_BITS-1:0] data;
  } parcel_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_SKIP    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_FAULTED = 2'd2;

  // A parcel starts a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(input logic [PARCEL_BITS-1:0] p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv_parcel_queue.sv
// Circular parcel buffer: pushes up to PUSH_MAX parcels, pops 0/1/2, shows the two head entries.
module rv_parcel_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PUSH_MAX = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1,
  localparam int unsigned PW = $clog2(PUSH_MAX + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [PW-1:0]            push_cnt,
  input  parcel_t [PUSH_MAX-1:0]   push_data,
  input  logic [1:0]               pop_cnt,
  output parcel_t                  head0,
  output parcel_t                  head1,
  output logic [CW-1:0]            count
);

  parcel_t       mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr [PUSH_MAX];
  logic [AW-1:0] rd_addr1;
  logic          full;

  // Write slot for each parcel of the incoming group.
  always_comb begin
    for (int i = 0; i < PUSH_MAX; i++) begin
      wr_addr[i] = wr_ptr[AW-1:0] + AW'(i);
    end
  end

  // Parcel storage; no reset needed since only entries below count are ever consumed.
  always_ff @(posedge clock) begin
    if (!flush) begin
      for (int i = 0; i < PUSH_MAX; i++) begin
        if (PW'(i) < push_cnt) begin
          mem[wr_addr[i]] <= push_data[i];
        end
      end
    end
  end

  // Pointer update; a pop may consume parcels written in this same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + CW'(push_cnt);
      rd_ptr <= rd_ptr + CW'(pop_cnt);
    end
  end

  // Occupancy: differing pointer MSBs with equal low bits means full.
  always_comb begin
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count    = {full, wr_ptr[AW-1:0] - rd_ptr[AW-1:0]};
    rd_addr1 = rd_ptr[AW-1:0] + AW'(1);
    head0    = mem[rd_ptr[AW-1:0]];
    head1    = mem[rd_addr1];
  end

endmodule

// File: rtl/rv_fetch_aligner.sv
// Realigns fetch beats into whole RV C/32-bit instructions with their PC, one per cycle.
module rv_fetch_aligner
  import rv_fetch_pkg::*;
#(
  parameter bit          rv64          = 1'b1,
  parameter int unsigned FETCH_PARCELS = 2,
  parameter int unsigned QUEUE_PARCELS = 8,
  parameter logic [63:0] RESET_PC      = '0,
  localparam int unsigned XLEN = rv64 ? 64 : 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                fetch_valid,
  output logic                                fetch_ready,
  input  logic [PARCEL_BITS*FETCH_PARCELS-1:0] fetch_data,
  input  logic                                fetch_fault,
  input  logic                                redirect_valid,
  input  logic [XLEN-1:0]                     redirect_pc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [31:0]                         out_instr,
  output logic                                out_is_compressed,
  output logic [XLEN-1:0]                     out_pc,
  output logic                                out_fault
);

  localparam int unsigned OFF_W = $clog2(FETCH_PARCELS);
  localparam int unsigned CW    = $clog2(QUEUE_PARCELS) + 1;
  localparam int unsigned AVW   = CW + 1;
  localparam int unsigned PW    = $clog2(FETCH_PARCELS + 1);

  state_t                              state;
  state_t                              state_nx;
  logic [OFF_W-1:0]                    skip_off;
  logic [OFF_W-1:0]                    off;
  logic [XLEN-1:0]                     head_pc;
  logic [CW-1:0]                       q_count;
  logic [CW-1:0]                       q_free;
  parcel_t                             q_head0;
  parcel_t                             q_head1;
  parcel_t [FETCH_PARCELS-1:0]         push_data;
  logic [PW-1:0]                       push_cnt;
  logic [1:0]                          pop_cnt;
  logic [PARCEL_BITS*FETCH_PARCELS-1:0] beat_shifted;
  logic [AVW-1:0]                      avail;
  parcel_t                             p0;
  parcel_t                             p1;
  logic                                accept;
  logic                                is_c;
  logic                                need2;
  logic                                flt;
  logic                                ext_ok;
  logic                                load;
  logic [31:0]                         instr_nx;
  logic                                unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  // Ready depends only on registered occupancy/state and the redirect input.
  assign q_free      = CW'(QUEUE_PARCELS) - q_count;
  assign fetch_ready = (q_free >= CW'(FETCH_PARCELS)) && !redirect_valid && (state != ST_FAULTED);
  assign accept      = fetch_valid && fetch_ready;

  // Drop the leading parcels of the first beat after a misaligned restart.
  always_comb begin
    off          = (state == ST_SKIP) ? skip_off : '0;
    beat_shifted = fetch_data >> {off, 4'b0000};
    push_cnt     = accept ? (PW'(FETCH_PARCELS) - PW'(off)) : '0;
    for (int i = 0; i < FETCH_PARCELS; i++) begin
      push_data[i].fault = fetch_fault;
      push_data[i].data  = beat_shifted[PARCEL_BITS*i +: PARCEL_BITS];
    end
  end

  // Extract view over queued parcels followed by the beat arriving this cycle.
  always_comb begin
    avail = {1'b0, q_count} + AVW'(push_cnt);
    p0    = (q_count != '0) ? q_head0 : push_data[0];
    if (q_count >= CW'(2)) begin
      p1 = q_head1;
    end else if (q_count == CW'(1)) begin
      p1 = push_data[0];
    end else begin
      p1 = push_data[1];
    end
    is_c   = is_compressed(p0.data);
    need2  = !is_c && !p0.fault;
    flt    = p0.fault || (need2 && p1.fault);
    ext_ok = (avail != '0) && (state != ST_FAULTED) && (!need2 || (avail >= AVW'(2)));
    load   = ext_ok && (!out_valid || out_ready) && !redirect_valid;
    pop_cnt = load ? (need2 ? 2'd2 : 2'd1) : 2'd0;
    if (flt) begin
      instr_nx = '0;
    end else if (is_c) begin
      instr_nx = {16'h0000, p0.data};
    end else begin
      instr_nx = {p1.data, p0.data};
    end
  end

  rv_parcel_queue #(
    .DEPTH    (QUEUE_PARCELS),
    .PUSH_MAX (FETCH_PARCELS)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .head0     (q_head0),
    .head1     (q_head1),
    .count     (q_count)
  );

  // Next state: redirect wins, then a faulted extract, then first beat after restart.
  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      state_nx = ST_SKIP;
    end else if (load && flt) begin
      state_nx = ST_FAULTED;
    end else if (accept && (state == ST_SKIP)) begin
      state_nx = ST_RUN;
    end
  end

  // State, restart offset and PC of the head parcel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_SKIP;
      head_pc  <= XLEN'(RESET_PC);
      skip_off <= RESET_PC[1 +: OFF_W];
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        head_pc  <= {redirect_pc[XLEN-1:1], 1'b0};
        skip_off <= redirect_pc[1 +: OFF_W];
      end else if (load) begin
        head_pc <= head_pc + XLEN'({pop_cnt, 1'b0});
      end
    end
  end

  // Single-entry output register; holds while stalled, cleared by redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_instr         <= '0;
      out_is_compressed <= 1'b0;
      out_pc            <= '0;
      out_fault         <= 1'b0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_instr         <= instr_nx;
      out_is_compressed <= is_c && !flt;
      out_pc            <= head_pc;
      out_fault         <= flt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
